// File: rtl/wave_column_if.sv
// Bus bundle for wave_column_engine: column load port, step control,
// per-row neighbour exchange and the u_n+1 output stream.
interface wave_column_if #(
  parameter int DW = 18,
  parameter int AW = 6
);
  logic          init_start;
  logic          init_valid;
  logic [DW-1:0] init_u_n;
  logic [DW-1:0] init_u_nm1;
  logic          init_ready;
  logic [DW-1:0] rho;
  logic          step_start;
  logic          step_busy;
  logic          step_done;
  logic [AW-1:0] row_idx;
  logic          row_calc;
  logic [DW-1:0] nbr_w;
  logic [DW-1:0] nbr_e;
  logic [DW-1:0] u_np1;
  logic          u_np1_valid;
  logic [DW-1:0] tap_out;

  modport master (
    output init_start, init_valid, init_u_n, init_u_nm1, rho, step_start,
           nbr_w, nbr_e,
    input  init_ready, step_busy, step_done, row_idx, row_calc, u_np1,
           u_np1_valid, tap_out
  );

  modport slave (
    input  init_start, init_valid, init_u_n, init_u_nm1, rho, step_start,
           nbr_w, nbr_e,
    output init_ready, step_busy, step_done, row_idx, row_calc, u_np1,
           u_np1_valid, tap_out
  );
endinterface

// File: rtl/wave_column_engine.sv
// One column of a finite-difference membrane solver. u_n and u_n-1 live in
// two synchronous-read RAMs; each step sweeps rows 0..NUM_ROW-1 through a
// 3-entry u_n window (below/cur/above), exchanging neighbours over the bus.
module wave_column_engine #(
  parameter int DW         = 18,
  parameter int NUM_ROW    = 33,
  parameter int AW         = $clog2(NUM_ROW),
  parameter int DAMP_SHIFT = 10,
  parameter int TAP_ROW    = NUM_ROW / 2
) (
  input logic         clk,
  input logic         rst,
  wave_column_if.slave bus
);
  localparam int W = DW + 3;
  localparam int PW = W + DW + 1;
  localparam logic signed [W-1:0] SAT_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = -SAT_MAX;
  localparam logic [AW-1:0] LAST_ROW = AW'(NUM_ROW - 1);
  localparam logic [AW-1:0] TAP_IDX  = AW'(TAP_ROW);

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_PRIME1, S_PRIME2, S_CALC, S_WB, S_DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] row_q;
  logic [DW-1:0] rho_q;
  logic [DW-1:0] b_q, c_q, a_q;
  logic          init_ready_q, busy_q, done_q, calc_q, valid_q;
  logic [DW-1:0] u_np1_q, tap_q;

  logic [DW-1:0] un_ram_q  [NUM_ROW];
  logic [DW-1:0] nm1_ram_q [NUM_ROW];
  logic [DW-1:0] un_rd_q, nm1_rd_q;

  logic          mem_we, un_re, nm1_re;
  logic [AW-1:0] waddr, un_raddr, nm1_raddr;
  logic [DW-1:0] un_wdata, nm1_wdata;

  logic [DW-1:0]        a_raw;
  logic signed [W-1:0]  u_s, w_s, e_s, a_s, b_s, m_s;
  logic signed [W-1:0]  lap, term, am_v, t_v, y_v, res;
  logic signed [PW-1:0] rho_x, lap_x, prod_v;

  // RAM port control: load writes, WB write-back, and look-ahead reads that
  // keep the window one row ahead of the row being computed
  always_comb begin
    mem_we    = 1'b0;
    waddr     = '0;
    un_wdata  = '0;
    nm1_wdata = '0;
    un_re     = 1'b0;
    un_raddr  = '0;
    nm1_re    = 1'b0;
    nm1_raddr = '0;
    case (state_q)
      S_LOAD: begin
        mem_we    = bus.init_valid && init_ready_q && !rst;
        waddr     = ptr_q;
        un_wdata  = bus.init_u_n;
        nm1_wdata = bus.init_u_nm1;
      end
      S_PRIME1: begin
        un_re    = 1'b1;
        un_raddr = '0;
      end
      S_PRIME2: begin
        un_re     = 1'b1;
        un_raddr  = AW'(1);
        nm1_re    = 1'b1;
        nm1_raddr = '0;
      end
      S_WB: begin
        mem_we    = !rst;
        waddr     = row_q;
        un_wdata  = u_np1_q;
        nm1_wdata = c_q;
        // Row r+2 becomes the next "above"; nothing past the last row
        if (int'(row_q) + 2 < NUM_ROW) begin
          un_re    = 1'b1;
          un_raddr = row_q + AW'(2);
        end
        if (int'(row_q) + 1 < NUM_ROW) begin
          nm1_re    = 1'b1;
          nm1_raddr = row_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Column storage and synchronous reads; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      un_ram_q[waddr]  <= un_wdata;
      nm1_ram_q[waddr] <= nm1_wdata;
    end
    if (un_re)  un_rd_q  <= un_ram_q[un_raddr];
    if (nm1_re) nm1_rd_q <= nm1_ram_q[nm1_raddr];
  end

  // Node update at DW+3 bits: laplacian, rho scaling, damping, saturation
  always_comb begin
    a_raw  = (row_q == LAST_ROW) ? '0 : un_rd_q;
    u_s    = {{3{c_q[DW-1]}}, c_q};
    b_s    = {{3{b_q[DW-1]}}, b_q};
    a_s    = {{3{a_raw[DW-1]}}, a_raw};
    w_s    = {{3{bus.nbr_w[DW-1]}}, bus.nbr_w};
    e_s    = {{3{bus.nbr_e[DW-1]}}, bus.nbr_e};
    m_s    = {{3{nm1_rd_q[DW-1]}}, nm1_rd_q};
    lap    = (w_s - u_s) + (e_s - u_s) + (a_s - u_s) + (b_s - u_s);
    rho_x  = {{(PW-DW){1'b0}}, rho_q};
    lap_x  = {{(PW-W){lap[W-1]}}, lap};
    prod_v = rho_x * lap_x;
    term   = W'(prod_v >>> (DW - 1));
    am_v   = m_s - (m_s >>> DAMP_SHIFT);
    t_v    = (u_s <<< 1) + term - am_v;
    y_v    = t_v - (t_v >>> DAMP_SHIFT);
    if (y_v > SAT_MAX)      res = SAT_MAX;
    else if (y_v < SAT_MIN) res = SAT_MIN;
    else                    res = y_v;
  end

  // Control FSM with registered handshake, stream and tap outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      ptr_q        <= '0;
      row_q        <= '0;
      rho_q        <= '0;
      b_q          <= '0;
      c_q          <= '0;
      a_q          <= '0;
      init_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      calc_q       <= 1'b0;
      valid_q      <= 1'b0;
      u_np1_q      <= '0;
      tap_q        <= '0;
    end else begin
      done_q  <= 1'b0;
      calc_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (bus.init_valid && init_ready_q) begin
            if (ptr_q == LAST_ROW) begin
              state_q      <= S_IDLE;
              init_ready_q <= 1'b0;
              ptr_q        <= '0;
            end else begin
              ptr_q <= ptr_q + AW'(1);
            end
          end
        end
        S_IDLE: begin
          if (bus.init_start) begin
            state_q      <= S_LOAD;
            ptr_q        <= '0;
            init_ready_q <= 1'b1;
          end else if (bus.step_start) begin
            state_q <= S_PRIME1;
            rho_q   <= bus.rho;
            busy_q  <= 1'b1;
          end
        end
        S_PRIME1: begin
          b_q     <= '0;
          state_q <= S_PRIME2;
        end
        S_PRIME2: begin
          c_q     <= un_rd_q;
          row_q   <= '0;
          calc_q  <= 1'b1;
          state_q <= S_CALC;
        end
        S_CALC: begin
          a_q     <= a_raw;
          u_np1_q <= DW'(res);
          valid_q <= 1'b1;
          if (row_q == TAP_IDX) tap_q <= DW'(res);
          state_q <= S_WB;
        end
        S_WB: begin
          // Window slides on old u_n values; the RAM write does not feed back
          b_q <= c_q;
          c_q <= a_q;
          if (row_q == LAST_ROW) begin
            state_q <= S_DONE;
          end else begin
            row_q   <= row_q + AW'(1);
            calc_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.init_ready  = init_ready_q;
  assign bus.step_busy   = busy_q;
  assign bus.step_done   = done_q;
  assign bus.row_idx     = row_q;
  assign bus.row_calc    = calc_q;
  assign bus.u_np1       = u_np1_q;
  assign bus.u_np1_valid = valid_q;
  assign bus.tap_out     = tap_q;
endmodule

// File: tb/tb_wave_column_engine.sv
// Randomized self-checking bench for wave_column_engine with an
// arithmetic reference model of the column update.
module tb_wave_column_engine;
  localparam int DW  = 18;
  localparam int N   = 5;
  localparam int AW  = $clog2(N);
  localparam int DS  = 10;
  localparam int TAP = N / 2;
  localparam int W   = DW + 3;
  localparam longint MASK = (64'sd1 <<< DW) - 1;
  localparam longint SMAX = (64'sd1 <<< (DW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  wave_column_if #(.DW(DW), .AW(AW)) bus ();

  wave_column_engine #(
    .DW(DW), .NUM_ROW(N), .AW(AW), .DAMP_SHIFT(DS), .TAP_ROW(TAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] nw [8];
  logic [DW-1:0] ne [8];
  logic [DW-1:0] ld_un [N];
  logic [DW-1:0] ld_nm1 [N];
  longint un_m [N];
  longint unm1_m [N];
  longint exp_m [N];
  longint got_v [N];
  longint tap_m = 0;

  assign bus.nbr_w = nw[bus.row_idx];
  assign bus.nbr_e = ne[bus.row_idx];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint wrapw(input longint x);
    logic signed [W-1:0] b;
    b = W'(x);
    return longint'(b);
  endfunction

  function automatic longint alp(input longint x);
    return x - (x >>> DS);
  endfunction

  // Reference: one explicit time step over the whole column using old u_n
  task automatic model_step(input longint rho_l);
    longint old [N];
    longint u, a, b, lap, term, t, y;
    for (int r = 0; r < N; r++) old[r] = un_m[r];
    for (int r = 0; r < N; r++) begin
      u = old[r];
      b = (r > 0) ? old[r-1] : 0;
      a = (r < N - 1) ? old[r+1] : 0;
      lap = sx(nw[r]) + sx(ne[r]) + a + b - 4 * u;
      term = wrapw((rho_l * lap) >>> (DW - 1));
      t = wrapw(2 * u + term - alp(unm1_m[r]));
      y = alp(t);
      if (y > SMAX) y = SMAX;
      if (y < -SMAX) y = -SMAX;
      exp_m[r] = y & MASK;
      unm1_m[r] = u;
      un_m[r] = y;
      if (r == TAP) tap_m = y;
    end
  endtask

  task automatic enter_load(input bit with_step);
    bus.init_start = 1'b1;
    bus.step_start = with_step;
    @(posedge clk); #1;
    bus.init_start = 1'b0;
    bus.step_start = 1'b0;
    check("reload_ready", longint'(bus.init_ready), 1);
    check("reload_busy", longint'(bus.step_busy), 0);
  endtask

  task automatic load_col();
    int i;
    bit v;
    for (int k = 0; k < N; k++) begin
      un_m[k] = sx(ld_un[k]);
      unm1_m[k] = sx(ld_nm1[k]);
    end
    i = 0;
    while (i < N) begin
      v = ($urandom_range(3) != 0);
      bus.init_valid = v;
      bus.init_u_n = ld_un[i];
      bus.init_u_nm1 = ld_nm1[i];
      @(posedge clk); #1;
      if (v) i++;
    end
    bus.init_valid = 1'b0;
    check("load_ready_low", longint'(bus.init_ready), 0);
  endtask

  task automatic run_step(input logic [DW-1:0] rho_v, input bit poke);
    int cnt;
    int done_c;
    model_step(longint'(rho_v));
    bus.rho = rho_v;
    bus.step_start = 1'b1;
    @(posedge clk); #1;
    bus.step_start = 1'b0;
    bus.rho = DW'($urandom);
    check("busy_start", longint'(bus.step_busy), 1);
    cnt = 0;
    done_c = -1;
    for (int c = 1; c <= 4 * N + 20; c++) begin
      bus.step_start = poke && (c == 4);
      @(posedge clk); #1;
      if (bus.u_np1_valid) begin
        if (cnt < N) begin
          check("wb_row", longint'(bus.row_idx), cnt);
          check("u_np1", longint'(bus.u_np1), exp_m[cnt]);
          got_v[cnt] = longint'(bus.u_np1);
        end
        cnt++;
      end
      if (bus.step_done) begin
        done_c = c;
        break;
      end
    end
    bus.step_start = 1'b0;
    check("done_cycle", done_c, 2 * N + 3);
    check("wb_count", cnt, N);
    check("busy_end", longint'(bus.step_busy), 0);
    check("tap", longint'(bus.tap_out), tap_m & MASK);
    @(posedge clk); #1;
    check("done_single", longint'(bus.step_done), 0);
    check("idle_busy", longint'(bus.step_busy), 0);
  endtask

  task automatic fill(input logic [DW-1:0] un_v, input logic [DW-1:0] nm1_v,
                      input logic [DW-1:0] nb_v);
    for (int k = 0; k < N; k++) begin
      ld_un[k] = un_v;
      ld_nm1[k] = nm1_v;
    end
    for (int k = 0; k < 8; k++) begin
      nw[k] = nb_v;
      ne[k] = nb_v;
    end
  endtask

  task automatic rand_col();
    for (int k = 0; k < N; k++) begin
      ld_un[k] = DW'($urandom);
      ld_nm1[k] = DW'($urandom);
    end
  endtask

  task automatic rand_nbr();
    for (int k = 0; k < 8; k++) begin
      nw[k] = DW'($urandom);
      ne[k] = DW'($urandom);
    end
  endtask

  initial begin
    int seen;
    int dones;
    bus.init_start = 1'b0;
    bus.init_valid = 1'b0;
    bus.init_u_n = '0;
    bus.init_u_nm1 = '0;
    bus.rho = '0;
    bus.step_start = 1'b0;
    fill('0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", longint'(bus.init_ready), 1);
    check("rst_busy", longint'(bus.step_busy), 0);
    check("rst_done", longint'(bus.step_done), 0);
    check("rst_calc", longint'(bus.row_calc), 0);
    check("rst_valid", longint'(bus.u_np1_valid), 0);
    check("rst_u_np1", longint'(bus.u_np1), 0);
    check("rst_tap", longint'(bus.tap_out), 0);
    check("rst_row", longint'(bus.row_idx), 0);
    rst = 1'b0;

    // all-zero column stays zero
    fill('0, '0, '0);
    load_col();
    run_step(DW'($urandom), 1'b0);

    // single bump in row 2
    enter_load(1'b0);
    fill('0, '0, '0);
    ld_un[2] = 18'h08000;
    ld_nm1[2] = 18'h08000;
    load_col();
    run_step(18'h08000, 1'b0);
    check("bump_r0", got_v[0], 0);
    check("bump_r1", got_v[1], 18'h01FF8);
    check("bump_r2", got_v[2], 18'h00020);
    check("bump_r3", got_v[3], 18'h01FF8);
    check("bump_r4", got_v[4], 0);

    // 2u exceeds DW but not the wide intermediate
    enter_load(1'b0);
    fill(18'h10000, 18'h10000, '0);
    load_col();
    run_step('0, 1'b0);
    for (int r = 0; r < N; r++) check("wide_2u", got_v[r], 18'h10000);

    // neighbour drive only
    enter_load(1'b0);
    fill('0, '0, 18'h04000);
    load_col();
    run_step(18'h08000, 1'b0);
    for (int r = 0; r < N; r++) check("nbr_only", got_v[r], 18'h01FF8);
    check("nbr_tap", longint'(bus.tap_out), 18'h01FF8);

    // positive saturation
    enter_load(1'b0);
    fill(18'h1FFFF, 18'h20001, 18'h1FFFF);
    load_col();
    run_step(18'h1FFFF, 1'b0);
    for (int r = 0; r < N; r++) check("sat", got_v[r], 18'h1FFFF);

    // random column, consecutive steps, start pulse while busy
    enter_load(1'b0);
    rand_col();
    load_col();
    for (int s = 0; s < 4; s++) begin
      rand_nbr();
      run_step(DW'($urandom), s == 1);
    end

    // init_start beats step_start in IDLE
    enter_load(1'b1);
    rand_col();
    load_col();
    rand_nbr();
    run_step(DW'($urandom_range(18'h1FFFF)), 1'b0);

    // reset in the middle of a step
    bus.rho = 18'h08000;
    bus.step_start = 1'b1;
    @(posedge clk); #1;
    bus.step_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 4 * N + 20; c++) begin
      if (bus.row_calc && bus.row_idx == AW'(3)) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mid_row3_seen", seen, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tap_m = 0;
    check("abort_ready", longint'(bus.init_ready), 1);
    check("abort_busy", longint'(bus.step_busy), 0);
    check("abort_valid", longint'(bus.u_np1_valid), 0);
    check("abort_row", longint'(bus.row_idx), 0);
    dones = 0;
    for (int c = 0; c < 2 * N + 8; c++) begin
      @(posedge clk); #1;
      if (bus.step_done) dones++;
      if (bus.step_busy) dones++;
    end
    check("abort_no_done", dones, 0);
    rand_col();
    load_col();
    rand_nbr();
    run_step(DW'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
